// File: rtl/uart_line_buffer.sv
// uart_line_buffer: assembles received bytes into a line and echoes it.
// Bytes from the receive stream are stored until TERM_CHAR arrives. The
// stored line is then replayed on the transmit stream, with an optional
// trailing LF_CHAR. Once the buffer is full, further bytes are dropped and
// the sticky overflow flag is raised; a terminator still ends the line.
module uart_line_buffer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 256,
  parameter int                    ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [DATA_WIDTH-1:0] TERM_CHAR  = 8'h0D,
  parameter bit                    APPEND_LF  = 1'b1,
  parameter logic [DATA_WIDTH-1:0] LF_CHAR    = 8'h0A
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_data_valid,
  output logic                  rx_data_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_data_valid,
  input  logic                  tx_data_ready,
  output logic [ADDR_WIDTH:0]   line_len,
  output logic                  overflow,
  output logic                  busy
);

  typedef enum logic [1:0] {
    RECV    = 2'd0,
    SEND    = 2'd1,
    SEND_LF = 2'd2
  } state_t;

  // Line length at which the buffer is full; no more bytes are stored.
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     rd_ptr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    rx_acc;
  logic                    tx_acc;
  logic                    is_full;
  logic                    is_term;
  logic                    last_byte;
  logic [ADDR_WIDTH-1:0]   next_idx;

  assign rx_data_ready = (state_q == RECV);
  assign busy          = (state_q != RECV);
  assign rx_acc        = rx_data_valid && rx_data_ready;
  assign tx_acc        = tx_data_valid && tx_data_ready;
  assign is_full       = (line_len == FULL);
  assign is_term       = (rx_data == TERM_CHAR);
  // rd_ptr is the index of the byte currently presented on tx_data.
  assign last_byte     = (rd_ptr == (line_len - 1'b1));
  assign next_idx      = rd_ptr[ADDR_WIDTH-1:0] + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RECV;
    else        state_q <= state_d;
  end

  // Next-state: terminator starts the replay, last accepted byte ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RECV: begin
        if (rx_acc && is_term) state_d = SEND;
      end
      SEND: begin
        if (tx_acc && last_byte) state_d = APPEND_LF ? SEND_LF : RECV;
      end
      SEND_LF: begin
        if (tx_acc) state_d = RECV;
      end
      default: state_d = RECV;
    endcase
  end

  // Line storage; contents survive reset, only line_len marks them valid.
  always_ff @(posedge clk) begin
    if (rst_n && rx_acc && !is_full) mem[line_len[ADDR_WIDTH-1:0]] <= rx_data;
  end

  // Length/overflow bookkeeping and the transmit output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_len      <= '0;
      rd_ptr        <= '0;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      case (state_q)
        RECV: begin
          if (rx_acc) begin
            if (!is_full) line_len <= line_len + 1'b1;
            else          overflow <= 1'b1;
            if (is_term)  rd_ptr   <= '0;
          end
        end
        SEND: begin
          if (!tx_data_valid) begin
            // First cycle after entry: present byte 0.
            tx_data       <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            tx_data_valid <= 1'b1;
          end else if (tx_data_ready) begin
            if (last_byte) begin
              if (APPEND_LF) begin
                tx_data <= LF_CHAR;
              end else begin
                tx_data_valid <= 1'b0;
                line_len      <= '0;
                overflow      <= 1'b0;
              end
            end else begin
              // Back-to-back: next byte is presented right after the accept.
              rd_ptr  <= rd_ptr + 1'b1;
              tx_data <= mem[next_idx];
            end
          end
        end
        SEND_LF: begin
          if (tx_acc) begin
            tx_data_valid <= 1'b0;
            line_len      <= '0;
            overflow      <= 1'b0;
          end
        end
        default: begin
          tx_data_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_line_buffer.sv
// Bench for uart_line_buffer: three instances with different configurations
// share the stimulus; `sel` chooses which one is observed and checked.
module tb_uart_line_buffer;

  localparam int NDUT = 3;

  typedef logic [7:0] bq_t [$];

  typedef struct {
    logic [7:0] rxd;
    logic       rxv;
    logic       txr;
    logic       e_rxr;
    logic       e_txv;
    logic [7:0] e_txd;
    logic [8:0] e_len;
    logic       e_busy;
    logic       e_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic tx_ready = 1'b0;

  logic [NDUT-1:0] rxr, txv, ovf, bsy;
  logic [7:0] txd0, txd1, txd2;
  logic [8:0] len0;
  logic [2:0] len1;
  logic [4:0] len2;

  int sel = 0;
  logic       o_rx_ready, o_tx_valid, o_ovf, o_busy;
  logic [7:0] o_tx_data;
  logic [8:0] o_len;

  int n_chk = 0;
  int n_fail = 0;

  int         cfg_depth [NDUT] = '{256, 4, 16};
  logic [7:0] cfg_term  [NDUT] = '{8'h0D, 8'h0D, 8'h0A};
  bit         cfg_lf    [NDUT] = '{1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  uart_line_buffer #(.DATA_WIDTH(8), .DEPTH(256)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_valid),
    .rx_data_ready(rxr[0]), .tx_data(txd0), .tx_data_valid(txv[0]),
    .tx_data_ready(tx_ready), .line_len(len0), .overflow(ovf[0]), .busy(bsy[0]));

  uart_line_buffer #(.DATA_WIDTH(8), .DEPTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_valid),
    .rx_data_ready(rxr[1]), .tx_data(txd1), .tx_data_valid(txv[1]),
    .tx_data_ready(tx_ready), .line_len(len1), .overflow(ovf[1]), .busy(bsy[1]));

  uart_line_buffer #(.DATA_WIDTH(8), .DEPTH(16), .TERM_CHAR(8'h0A), .APPEND_LF(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_valid),
    .rx_data_ready(rxr[2]), .tx_data(txd2), .tx_data_valid(txv[2]),
    .tx_data_ready(tx_ready), .line_len(len2), .overflow(ovf[2]), .busy(bsy[2]));

  always_comb begin
    o_rx_ready = rxr[0]; o_tx_valid = txv[0]; o_ovf = ovf[0]; o_busy = bsy[0];
    o_tx_data = txd0; o_len = len0;
    case (sel)
      1: begin
        o_rx_ready = rxr[1]; o_tx_valid = txv[1]; o_ovf = ovf[1]; o_busy = bsy[1];
        o_tx_data = txd1; o_len = {6'b0, len1};
      end
      2: begin
        o_rx_ready = rxr[2]; o_tx_valid = txv[2]; o_ovf = ovf[2]; o_busy = bsy[2];
        o_tx_data = txd2; o_len = {4'b0, len2};
      end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d): got %0h, expected %0h", name, sel, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (dut %0d): bound expired", name, sel);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0; rx_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic str_line(input string s, input logic [7:0] term, output bq_t q);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    q.push_back(term);
  endtask

  // Offer each byte with random idle gaps, holding valid until accepted.
  task automatic drive_bytes(input bq_t q, input int max_gap);
    @(posedge clk); #1;
    foreach (q[i]) begin
      int gap;
      int t;
      bit acc;
      gap = int'($urandom_range(max_gap, 0));
      rx_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      rx_valid = 1'b1;
      rx_data  = q[i];
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = o_rx_ready;
        @(posedge clk); #1;
        t++;
      end
      if (!acc) begin
        fail_now("rx_accept");
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  // Gather transmitted bytes under a tx_ready pattern and compare with exp.
  // rmode: -1 = ready one cycle in three, else percent chance of ready.
  task automatic collect(input bq_t exp, input int rmode, input int exp_len, input bit exp_ovf);
    bq_t got;
    int cyc;
    bit pv, pr, first;
    logic [7:0] pd;
    got = {}; cyc = 0; pv = 0; pr = 0; pd = '0; first = 1;
    @(posedge clk); #1;
    while (got.size() < exp.size() && cyc < 3000) begin
      if (rmode < 0) tx_ready = (cyc % 3 == 0);
      else           tx_ready = ($urandom_range(99, 0) < rmode);
      @(negedge clk);
      if (pv && !pr) begin
        chk("tx_valid_hold", o_tx_valid, 1);
        chk("tx_data_hold", o_tx_data, pd);
      end
      if (o_tx_valid) begin
        chk("rx_ready_while_sending", o_rx_ready, 0);
        if (first) begin
          first = 0;
          chk("line_len_at_send", o_len, exp_len);
          chk("overflow_at_send", o_ovf, exp_ovf);
        end
      end
      if (o_tx_valid && tx_ready) got.push_back(o_tx_data);
      pv = o_tx_valid; pr = tx_ready; pd = o_tx_data;
      @(posedge clk); #1;
      cyc++;
    end
    if (got.size() < exp.size()) fail_now("tx_collect");
    tx_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_tx_valid", o_tx_valid, 0);
    end
    chk("idle_busy", o_busy, 0);
    chk("idle_line_len", o_len, 0);
    chk("idle_overflow", o_ovf, 0);
    chk("idle_rx_ready", o_rx_ready, 1);
    chk("tx_count", got.size(), exp.size());
    foreach (exp[i]) if (i < got.size()) chk("tx_byte", got[i], exp[i]);
    tx_ready = 1'b0;
  endtask

  // Reference: the first DEPTH bytes of the line come back, then LF if enabled.
  task automatic run_line(input int s, input bq_t q, input int rmode, input int max_gap, input bit rst);
    bq_t exp;
    int n, d, elen;
    bit eovf;
    if (rst) do_reset();
    sel = s;
    n = q.size();
    d = cfg_depth[s];
    exp = {};
    for (int i = 0; i < n && i < d; i++) exp.push_back(q[i]);
    if (cfg_lf[s]) exp.push_back(8'h0A);
    elen = (n < d) ? n : d;
    eovf = (n > d);
    fork
      drive_bytes(q, max_gap);
      collect(exp, rmode, elen, eovf);
    join
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[14];
    bq_t q;
    bq_t q1;

    vt[0]  = '{8'h41, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 9'd1, 1'b0, 1'b0};
    vt[1]  = '{8'h42, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 9'd2, 1'b0, 1'b0};
    vt[2]  = '{8'h0D, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 9'd3, 1'b1, 1'b0};
    vt[3]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 9'd3, 1'b1, 1'b0};
    vt[4]  = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41, 9'd3, 1'b1, 1'b0};
    vt[5]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h42, 9'd3, 1'b1, 1'b0};
    vt[6]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0D, 9'd3, 1'b1, 1'b0};
    vt[7]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0A, 9'd3, 1'b1, 1'b0};
    vt[8]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0A, 9'd3, 1'b1, 1'b0};
    vt[9]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 9'd0, 1'b0, 1'b0};
    vt[10] = '{8'h0D, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 9'd1, 1'b1, 1'b0};
    vt[11] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0D, 9'd1, 1'b1, 1'b0};
    vt[12] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0A, 9'd1, 1'b1, 1'b0};
    vt[13] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 9'd0, 1'b0, 1'b0};

    // Reset state of every instance.
    do_reset();
    #1;
    for (int s = 0; s < NDUT; s++) begin
      sel = s;
      #1;
      chk("rst_tx_valid", o_tx_valid, 0);
      chk("rst_tx_data", o_tx_data, 0);
      chk("rst_line_len", o_len, 0);
      chk("rst_overflow", o_ovf, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_rx_ready", o_rx_ready, 1);
    end

    // Cycle-exact vectors: "AB"+CR with a stall, then a CR-only line.
    sel = 0;
    foreach (vt[i]) begin
      @(negedge clk);
      rx_data = vt[i].rxd; rx_valid = vt[i].rxv; tx_ready = vt[i].txr;
      @(posedge clk); #1;
      chk("vec_rx_ready", o_rx_ready, vt[i].e_rxr);
      chk("vec_tx_valid", o_tx_valid, vt[i].e_txv);
      if (vt[i].e_txv) chk("vec_tx_data", o_tx_data, vt[i].e_txd);
      chk("vec_line_len", o_len, vt[i].e_len);
      chk("vec_busy", o_busy, vt[i].e_busy);
      chk("vec_overflow", o_ovf, vt[i].e_ovf);
    end
    @(negedge clk);
    rx_valid = 1'b0; tx_ready = 1'b0;

    // Directed lines through the model.
    str_line("AB", 8'h0D, q);    run_line(0, q, 100, 0, 1'b1);
    str_line("", 8'h0D, q);      run_line(0, q, 100, 0, 1'b1);
    str_line("Hello", 8'h0D, q); run_line(0, q, -1, 0, 1'b1);
    str_line("hi", 8'h0A, q);    run_line(2, q, 100, 0, 1'b1);
    str_line("ABC", 8'h0D, q);   run_line(1, q, 100, 0, 1'b1);
    str_line("ABCD", 8'h0D, q);  run_line(1, q, 100, 0, 1'b1);

    // Overflow on a 4-entry buffer, checked byte by byte.
    do_reset();
    sel = 1;
    for (int i = 0; i < 6; i++) begin
      q1 = {};
      q1.push_back(8'h41 + 8'(i));
      drive_bytes(q1, 0);
      chk("ovf_flag_step", o_ovf, (i >= 4) ? 1 : 0);
      chk("ovf_len_step", o_len, (i >= 3) ? 4 : i + 1);
    end
    q1 = {};
    q1.push_back(8'h0D);
    drive_bytes(q1, 0);
    q = {8'h41, 8'h42, 8'h43, 8'h44, 8'h0A};
    collect(q, 100, 4, 1'b1);

    // Reset pulse in the middle of a replay, then a fresh line.
    do_reset();
    sel = 0;
    str_line("XYZ", 8'h0D, q);
    drive_bytes(q, 0);
    @(negedge clk);
    chk("latency_not_yet_valid", o_tx_valid, 0);
    chk("busy_after_term", o_busy, 1);
    @(negedge clk);
    chk("latency_first_valid", o_tx_valid, 1);
    chk("latency_first_data", o_tx_data, 8'h58);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_tx_valid", o_tx_valid, 0);
    chk("midrst_line_len", o_len, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_rx_ready", o_rx_ready, 1);
    chk("midrst_tx_data", o_tx_data, 0);
    str_line("ok", 8'h0D, q);
    run_line(0, q, 100, 0, 1'b0);

    // Randomized lines on all configurations.
    for (int k = 0; k < 24; k++) begin
      int s, blen;
      s = k % NDUT;
      blen = int'($urandom_range(9, 0));
      q = {};
      for (int j = 0; j < blen; j++) begin
        logic [7:0] b;
        b = 8'($urandom_range(255, 0));
        if (b == cfg_term[s]) b = b ^ 8'h01;
        q.push_back(b);
      end
      q.push_back(cfg_term[s]);
      run_line(s, q, int'($urandom_range(100, 30)), int'($urandom_range(2, 0)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
